// File: rtl/dst_pkg.sv
// Shared constants for the 4x4 DST datapath.
package dst_pkg;
  localparam int DST_N  = 4;
  localparam int DST_NN = DST_N * DST_N;
endpackage

// File: rtl/dst_norm_elem.sv
// Single-coefficient normalizer: round-half-up right shift, then narrow to OUT_W.
// DST_NORMALIZE_SAT_EN selects saturating narrowing (clamp flag live) over wrap-around.
module dst_norm_elem #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 16,
  parameter int SHIFT = 14
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [OUT_W-1:0] y,
  output logic                    clamp
);

  // Half an output LSB; zero when SHIFT is 0, so no rounding term is added.
  localparam logic signed [IN_W:0] HALF = (IN_W+1)'((64'd1 << SHIFT) >> 1);
`ifdef DST_NORMALIZE_SAT_EN
  localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'((64'd1 << (OUT_W-1)) - 64'd1);
  localparam logic signed [IN_W:0] MIN_V = ~MAX_V;
`endif

  function automatic logic signed [IN_W:0] round_shift(input logic signed [IN_W:0] v);
    logic signed [IN_W:0] s;
    s = v + HALF;
    return s >>> SHIFT;
  endfunction

  // Returns {clamp_flag, narrowed_value}.
  function automatic logic [OUT_W:0] narrow(input logic signed [IN_W:0] v);
`ifdef DST_NORMALIZE_SAT_EN
    if (v > MAX_V) return {1'b1, MAX_V[OUT_W-1:0]};
    if (v < MIN_V) return {1'b1, MIN_V[OUT_W-1:0]};
`endif
    return {1'b0, v[OUT_W-1:0]};
  endfunction

  logic [OUT_W:0] nar_p0;

  always_comb begin
    nar_p0 = narrow(round_shift({x[IN_W-1], x}));
    y      = nar_p0[OUT_W-1:0];
    clamp  = nar_p0[OUT_W];
  end

endmodule

// File: rtl/dst_normalize.sv
// Post-transform normalization for 4x4 DST blocks: 16 parallel elements, one register stage.
// Build macro DST_NORMALIZE_SAT_EN enables saturation and a live out_sat.
module dst_normalize
  import dst_pkg::*;
#(
  parameter int IN_W  = 24,
  parameter int OUT_W = 16,
  parameter int SHIFT = 14
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               in_valid,
  input  logic signed [0:DST_N-1][0:DST_N-1][IN_W-1:0]       in_block,
  output logic                                               out_valid,
  output logic signed [0:DST_N-1][0:DST_N-1][OUT_W-1:0]      out_block,
  output logic                                               out_sat
);

  typedef logic [0:DST_N-1][0:DST_N-1][OUT_W-1:0] out_blk_t;

  out_blk_t            norm_p0;
  logic [DST_NN-1:0]   clamp_p0;

  for (genvar r = 0; r < DST_N; r++) begin : g_row
    for (genvar c = 0; c < DST_N; c++) begin : g_col
      dst_norm_elem #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
      ) u_elem (
        .x     ($signed(in_block[r][c])),
        .y     (norm_p0[r][c]),
        .clamp (clamp_p0[r*DST_N + c])
      );
    end
  end

  // ---- stage p0 -> p1: output register, enabled by in_valid ----
  out_blk_t blk_p1_d, blk_p1_q;
  logic     sat_p1_d, sat_p1_q;
  logic     vld_p1_d, vld_p1_q;

  always_comb begin
    blk_p1_d = blk_p1_q;
    sat_p1_d = sat_p1_q;
    vld_p1_d = in_valid;
    if (in_valid) begin
      blk_p1_d = norm_p0;
      sat_p1_d = |clamp_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      sat_p1_q <= 1'b0;
      blk_p1_q <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      sat_p1_q <= sat_p1_d;
      blk_p1_q <= blk_p1_d;
    end
  end

  assign out_valid = vld_p1_q;
  assign out_block = blk_p1_q;
  assign out_sat   = sat_p1_q;

endmodule

// File: tb/tb_dst_normalize.sv
// Directed bench: default, OUT_W=8 and SHIFT=0 identity instances share one stimulus.
module tb_dst_normalize;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic signed [0:3][0:3][23:0] in_block;

  logic def_vld, sat_vld, id_vld;
  logic def_sat, sat_sat, id_sat;
  logic signed [0:3][0:3][15:0] def_blk;
  logic signed [0:3][0:3][7:0]  sat_blk;
  logic signed [0:3][0:3][23:0] id_blk;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dst_normalize u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_block(in_block),
    .out_valid(def_vld), .out_block(def_blk), .out_sat(def_sat)
  );

  dst_normalize #(.IN_W(24), .OUT_W(8), .SHIFT(14)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_block(in_block),
    .out_valid(sat_vld), .out_block(sat_blk), .out_sat(sat_sat)
  );

  dst_normalize #(.IN_W(24), .OUT_W(24), .SHIFT(0)) u_id (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_block(in_block),
    .out_valid(id_vld), .out_block(id_blk), .out_sat(id_sat)
  );

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_blk(input int v [16]);
    for (int i = 0; i < 16; i++) in_block[i/4][i%4] = 24'(v[i]);
  endtask

  task automatic chk_def_blk(input string tag, input int exp [16]);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s[%0d]", tag, i), longint'($signed(def_blk[i/4][i%4])), longint'(exp[i]));
  endtask

  int mix_in  [16] = '{8192, -16384, 24576, 12288,
                       -4096, 2048, 8192, -1024,
                       16384, 32768, -8192, 4096,
                       -24576, -12288, 1024, 2048};
  int mix_exp [16] = '{1, -1, 2, 1,
                       0, 0, 1, 0,
                       1, 2, 0, 0,
                       -1, -1, 0, 0};
  int bnd_in  [16] = '{8191, 8192, -8193, -8192,
                       24575, 24576, 0, 0,
                       0, 0, 0, 0, 0, 0, 0, 0};
  int bnd_exp [16] = '{0, 1, -1, 0,
                       1, 2, 0, 0,
                       0, 0, 0, 0, 0, 0, 0, 0};
  int sat_in  [16] = '{8388607, -8388608, 0, 0,
                       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int zero_exp[16] = '{default: 0};

`ifdef DST_NORMALIZE_SAT_EN
  localparam int SAT_HI = 127;
  localparam int SAT_LO = -128;
  localparam int SAT_FLAG = 1;
`else
  localparam int SAT_HI = 0;
  localparam int SAT_LO = 0;
  localparam int SAT_FLAG = 0;
`endif

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_block = '0;
    step();
    step();

    chk("rst_vld", longint'(def_vld), 0);
    chk("rst_sat", longint'(def_sat), 0);
    chk_def_blk("rst_blk", zero_exp);

    rst = 1'b0;

    // Block A (mixed), then idle with different data on the bus, then block B.
    drive_blk(mix_in);
    in_valid = 1'b1;
    step();
    chk("mix_vld", longint'(def_vld), 1);
    chk("mix_sat", longint'(def_sat), 0);
    chk_def_blk("mix_blk", mix_exp);
    chk("mix8_sat", longint'(sat_sat), 0);
    chk("mix8_e02", longint'($signed(sat_blk[0][2])), 2);

    in_valid = 1'b0;
    drive_blk(bnd_in);
    step();
    chk("gap_vld", longint'(def_vld), 0);
    chk_def_blk("gap_hold", mix_exp);

    in_valid = 1'b1;
    step();
    chk("bnd_vld", longint'(def_vld), 1);
    chk_def_blk("bnd_blk", bnd_exp);

    // Full-scale inputs: clamp (or wrap) at OUT_W=8, pass-through at SHIFT=0.
    drive_blk(sat_in);
    step();
    chk("sat_hi", longint'($signed(sat_blk[0][0])), longint'(SAT_HI));
    chk("sat_lo", longint'($signed(sat_blk[0][1])), longint'(SAT_LO));
    chk("sat_flag", longint'(sat_sat), longint'(SAT_FLAG));
    chk("sat_zero", longint'($signed(sat_blk[0][2])), 0);
    chk("def_big_hi", longint'($signed(def_blk[0][0])), 512);
    chk("def_big_lo", longint'($signed(def_blk[0][1])), -512);
    chk("def_big_sat", longint'(def_sat), 0);
    chk("id_hi", longint'($signed(id_blk[0][0])), 8388607);
    chk("id_lo", longint'($signed(id_blk[0][1])), -8388608);
    chk("id_sat", longint'(id_sat), 0);
    chk("id_vld", longint'(id_vld), 1);

    // A clean block afterwards must clear the flag.
    drive_blk(mix_in);
    step();
    chk("sat_clear", longint'(sat_sat), 0);
    chk("sat_clear_e00", longint'($signed(sat_blk[0][0])), 1);

    // Reset while a saturating block is offered: it must be discarded.
    drive_blk(sat_in);
    rst = 1'b1;
    step();
    chk("mrst_vld", longint'(def_vld), 0);
    chk("mrst_sat_vld", longint'(sat_vld), 0);
    chk("mrst_sat", longint'(sat_sat), 0);
    chk("mrst_sat_e00", longint'($signed(sat_blk[0][0])), 0);
    chk("mrst_id_e00", longint'($signed(id_blk[0][0])), 0);
    chk_def_blk("mrst_blk", zero_exp);

    rst = 1'b0;
    drive_blk(mix_in);
    step();
    chk("resume_vld", longint'(def_vld), 1);
    chk_def_blk("resume_blk", mix_exp);

    in_valid = 1'b0;
    step();
    chk("tail_vld", longint'(def_vld), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
